dest_req_arb_wrr: RTL and testbench
===================================

# dest_req_arb_wrr

Weighted round-robin arbiter merging N_DESTS `req_t` request streams onto one registered `m_req` output, successor to the plain RR destination arbiter. Adds per-destination weights, a per-destination outstanding-request limit with completion-driven credit return, a configurable drop filter, and a mux-sequence queue entry (`mux_user_t`) per forwarded request. Sits between user destination request ports and the shared request channel; `mux` drives the downstream data multiplexer.

## Interface
- N_DESTS, 4: number of request inputs, 1..16; N_DESTS_BITS = clog2s(N_DESTS).
- WEIGHT_BITS, 4: width of each per-destination weight.
- MAX_OUTST, 8: max forwarded-but-uncompleted requests per destination, 1..255.
- SEQ_DEPTH, N_OUTSTANDING_REGION: depth of mux sequence queue.
- DROP_OFFS, 6: `offs` value discarded when drop filter enabled.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; one clock, asynchronous, active-low.
- s_req[N_DESTS]  metaIntf.s  req_t  request inputs.
- m_req  metaIntf.m  req_t  arbitrated request output, registered.
- mux  metaIntf.m  mux_user_t  {pid, len = beats-1, dest} per forwarded request.
- cfg_mode  in  1  0 = plain RR, 1 = weighted RR.
- cfg_weight  in  N_DESTS*WEIGHT_BITS  weight of dest i at [i*WEIGHT_BITS +: WEIGHT_BITS].
- cfg_drop_en  in  1  enable DROP_OFFS filter.
- cpl_valid  in  1  one completion returned.
- cpl_dest  in  N_DESTS_BITS  destination of completion.
- stat_drop_cnt  out  32  dropped-request count, wraps.
- err_cpl_underflow  out  1  sticky: completion for destination with zero outstanding.

## Operation
- Eligible(i) = s_req[i].valid && (dropping(i) || (out_cnt[i] < MAX_OUTST && seq queue not full && output stage ready)); dropping(i) = cfg_drop_en && s_req[i].data.offs == DROP_OFFS.
- Selection: first eligible index scanning rr_ptr, rr_ptr+1, … modulo N_DESTS. Grant = s_req[g].ready high; only granted input sees ready.
- Forwarded grant: request loaded into output stage; mux entry pushed same cycle with pid, dest = g, len = (len-1) >> BEAT_LOG_BITS, len == 0 yields 0; out_cnt[g]++.
- Dropped grant: consumed, no m_req, no mux entry, no credit; stat_drop_cnt++.
- Pointer update on any grant (forwarded or dropped) to g:
  - cfg_mode 0: rr_ptr = g+1 wrapping to 0; burst_cnt = 0.
  - cfg_mode 1: effective weight w = max(weight[g],1). If burst_cnt+1 < w: rr_ptr = g, burst_cnt++. Else rr_ptr = g+1 wrap, burst_cnt = 0.
  - If granted g ≠ rr_ptr (rr_ptr holder idle/ineligible), burst_cnt restarts counting for g.
- No grant: rr_ptr, burst_cnt hold.
- Credits: cpl_valid decrements out_cnt[cpl_dest]. Simultaneous grant and completion on same dest: net unchanged. Completion at out_cnt == 0: ignored, err_cpl_underflow set until reset. cpl_dest ≥ N_DESTS ignored, flags error.
- Mode/weight changes take effect at next grant decision; burst_cnt not cleared.

## Timing
- Reset (async assert, sync-safe release): rr_ptr 0, burst_cnt 0, all out_cnt 0, stat_drop_cnt 0, err_cpl_underflow 0, m_req.valid 0, mux.valid 0, all s_req.ready 0, queue empty.
- Grant combinational in cycle t; m_req.valid and mux.valid earliest t+1.
- Output stage 2-entry skid: one grant per cycle sustained while m_req.ready high; m_req.valid/data stable until accepted.
- Seq queue full: no forwarded grants; drops still proceed.
- Reset mid-burst: in-flight output and queue contents discarded; credits return to 0.
- cfg inputs sampled combinationally; stable across a grant cycle.

## Test plan
- N_DESTS=4, mode 0, all valid continuously, sinks always ready -> grant order 0,1,2,3,0… one per cycle; m_req.valid at cycle 1 after first grant.
- Mode 1, weights {3,1,0,2}, all valid -> order 0,0,0,1,2,3,3,0,0,0…; weight 0 behaves as 1.
- MAX_OUTST=2, dest 1 only, no completions -> exactly 2 forwarded, s_req[1].ready low; one cpl_valid dest 1 -> third forwarded next cycle.
- cfg_drop_en=1, dest 2 sends offs 6 then offs 0 -> first consumed, stat_drop_cnt=1, no mux entry; second forwarded with mux.dest=2.
- len=128, BEAT_LOG_BITS=6 -> mux.len=1; len=0 -> mux.len=0; m_req.ready low 20 cycles with SEQ_DEPTH=4 -> at most 4 mux entries, m_req data held stable.
- cpl_valid to dest 3 with out_cnt 0 -> err_cpl_underflow=1, counters unchanged; aresetn pulse mid-traffic -> all outputs to reset values immediately.

Source files
------------

// File: rtl/dest_req_arb_wrr.sv
// Weighted round-robin merge of N_DESTS request streams onto one registered output,
// with per-destination outstanding credits, an offs drop filter and a mux sequence queue.

module dest_req_arb_wrr_credit #(
   parameter int CNT_BITS  = 8,
   parameter int MAX_OUTST = 8
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic inc,
   input  logic cpl,
   output logic has_credit,
   output logic underflow
);
   logic [CNT_BITS-1:0] cnt;
   logic                dec;

   assign underflow  = cpl && (cnt == '0);
   assign dec        = cpl && (cnt != '0);
   assign has_credit = cnt < CNT_BITS'(MAX_OUTST);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         cnt <= '0;
      else if (inc && !dec)
         cnt <= cnt + CNT_BITS'(1);
      else if (dec && !inc)
         cnt <= cnt - CNT_BITS'(1);
   end
endmodule

module dest_req_arb_wrr #(
   parameter int N_DESTS       = 4,
   parameter int WEIGHT_BITS   = 4,
   parameter int MAX_OUTST     = 8,
   parameter int SEQ_DEPTH     = 8,
   parameter int DROP_OFFS     = 6,
   parameter int PID_BITS      = 6,
   parameter int LEN_BITS      = 16,
   parameter int OFFS_BITS     = 8,
   parameter int BEAT_LOG_BITS = 6,
   localparam int N_DESTS_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [N_DESTS-1:0]                    s_req_valid,
   output logic [N_DESTS-1:0]                    s_req_ready,
   input  logic [N_DESTS-1:0][PID_BITS-1:0]      s_req_pid,
   input  logic [N_DESTS-1:0][LEN_BITS-1:0]      s_req_len,
   input  logic [N_DESTS-1:0][OFFS_BITS-1:0]     s_req_offs,
   output logic                                  m_req_valid,
   input  logic                                  m_req_ready,
   output logic [PID_BITS-1:0]                   m_req_pid,
   output logic [LEN_BITS-1:0]                   m_req_len,
   output logic [OFFS_BITS-1:0]                  m_req_offs,
   output logic                                  mux_valid,
   input  logic                                  mux_ready,
   output logic [PID_BITS-1:0]                   mux_pid,
   output logic [LEN_BITS-1:0]                   mux_len,
   output logic [N_DESTS_BITS-1:0]               mux_dest,
   input  logic                                  cfg_mode,
   input  logic [N_DESTS*WEIGHT_BITS-1:0]        cfg_weight,
   input  logic                                  cfg_drop_en,
   input  logic                                  cpl_valid,
   input  logic [N_DESTS_BITS-1:0]               cpl_dest,
   output logic [31:0]                           stat_drop_cnt,
   output logic                                  err_cpl_underflow
);
   localparam int SW  = N_DESTS_BITS + 1;
   localparam int WB1 = WEIGHT_BITS + 1;
   localparam int QB  = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
   localparam int CB  = $clog2(SEQ_DEPTH + 1);
   localparam logic [SW-1:0]           N_W  = SW'(N_DESTS);
   localparam logic [N_DESTS_BITS-1:0] LAST = N_DESTS_BITS'(N_DESTS - 1);
   localparam logic [OFFS_BITS-1:0]    DROP_V = OFFS_BITS'(DROP_OFFS);

   typedef struct packed {
      logic [PID_BITS-1:0]  pid;
      logic [LEN_BITS-1:0]  len;
      logic [OFFS_BITS-1:0] offs;
   } req_s;

   typedef struct packed {
      logic [PID_BITS-1:0]     pid;
      logic [LEN_BITS-1:0]     len;
      logic [N_DESTS_BITS-1:0] dest;
   } mux_s;

   // run_q holds off grants until the first clock after reset release
   logic                          run_q;
   logic [N_DESTS_BITS-1:0]       rr_ptr;
   logic [WEIGHT_BITS-1:0]        burst_cnt;
   logic [N_DESTS-1:0][WEIGHT_BITS-1:0] wt;
   logic [N_DESTS-1:0]            drop_hit, elig, has_credit, under, cpl_hit;
   logic                          fwd_ok, gnt_vld, fwd, drop, cpl_dest_ok;
   logic [N_DESTS_BITS-1:0]       gnt_idx, scan_idx, ptr_nxt;
   logic [SW-1:0]                 scan_sum;
   logic [WEIGHT_BITS-1:0]        eff_w, base_cnt;
   logic [WB1-1:0]                nxt_cnt;
   logic                          stay;
   logic [LEN_BITS-1:0]           g_len, g_beats;

   req_s                          out_q, skd_q, new_req;
   logic                          out_vld, skd_vld, m_pop;

   mux_s                          q_mem [SEQ_DEPTH];
   logic [QB-1:0]                 wr_ptr, rd_ptr;
   logic [CB-1:0]                 q_cnt;
   logic                          q_full, q_pop;
   mux_s                          new_mux, q_head;

   assign wt     = cfg_weight;
   assign q_full = (q_cnt == CB'(SEQ_DEPTH));
   assign fwd_ok = !skd_vld && !q_full;

   generate
      for (genvar i = 0; i < N_DESTS; i++) begin : g_dest
         assign drop_hit[i] = cfg_drop_en && (s_req_offs[i] == DROP_V);
         assign elig[i]     = s_req_valid[i] && (drop_hit[i] || (has_credit[i] && fwd_ok));
         assign cpl_hit[i]  = cpl_valid && cpl_dest_ok && (cpl_dest == N_DESTS_BITS'(i));

         dest_req_arb_wrr_credit #(.CNT_BITS(8), .MAX_OUTST(MAX_OUTST)) u_credit (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .inc        (fwd && (gnt_idx == N_DESTS_BITS'(i))),
            .cpl        (cpl_hit[i]),
            .has_credit (has_credit[i]),
            .underflow  (under[i])
         );
      end
      if ((1 << N_DESTS_BITS) == N_DESTS) begin : g_cpl_full
         assign cpl_dest_ok = 1'b1;
      end else begin : g_cpl_chk
         assign cpl_dest_ok = {1'b0, cpl_dest} < N_W;
      end
   endgenerate

   // rotating-priority scan starting at rr_ptr
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < N_DESTS; k++) begin
         scan_sum = {1'b0, rr_ptr} + SW'(k);
         if (scan_sum >= N_W) scan_sum = scan_sum - N_W;
         scan_idx = scan_sum[N_DESTS_BITS-1:0];
         if (!gnt_vld && elig[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan_idx;
         end
      end
      gnt_vld = gnt_vld && run_q;
   end

   always_comb begin
      s_req_ready = '0;
      if (gnt_vld) s_req_ready[gnt_idx] = 1'b1;
   end

   assign fwd  = gnt_vld && !drop_hit[gnt_idx];
   assign drop = gnt_vld && drop_hit[gnt_idx];

   // a grant that skips the pointer holder starts a fresh burst for the new owner
   assign eff_w    = (wt[gnt_idx] == '0) ? WEIGHT_BITS'(1) : wt[gnt_idx];
   assign base_cnt = (gnt_idx == rr_ptr) ? burst_cnt : '0;
   assign nxt_cnt  = {1'b0, base_cnt} + WB1'(1);
   assign stay     = cfg_mode && (nxt_cnt < {1'b0, eff_w});
   assign ptr_nxt  = (gnt_idx == LAST) ? '0 : gnt_idx + N_DESTS_BITS'(1);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         run_q             <= 1'b0;
         rr_ptr            <= '0;
         burst_cnt         <= '0;
         stat_drop_cnt     <= '0;
         err_cpl_underflow <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (gnt_vld) begin
            if (stay) begin
               rr_ptr    <= gnt_idx;
               burst_cnt <= nxt_cnt[WEIGHT_BITS-1:0];
            end else begin
               rr_ptr    <= ptr_nxt;
               burst_cnt <= '0;
            end
         end
         if (drop) stat_drop_cnt <= stat_drop_cnt + 32'd1;
         if (cpl_valid && (!cpl_dest_ok || (|under))) err_cpl_underflow <= 1'b1;
      end
   end

   assign g_len   = s_req_len[gnt_idx];
   assign g_beats = (g_len == '0) ? '0 : ((g_len - LEN_BITS'(1)) >> BEAT_LOG_BITS);
   assign new_req = '{pid: s_req_pid[gnt_idx], len: g_len, offs: s_req_offs[gnt_idx]};
   assign new_mux = '{pid: s_req_pid[gnt_idx], len: g_beats, dest: gnt_idx};

   // two-entry output stage: out_q drives m_req, skd_q catches the grant made while stalled
   assign m_pop = out_vld && m_req_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_vld <= 1'b0;
         skd_vld <= 1'b0;
         out_q   <= '0;
         skd_q   <= '0;
      end else if (m_pop) begin
         if (skd_vld) begin
            out_q <= skd_q;
            if (fwd) skd_q <= new_req;
            else     skd_vld <= 1'b0;
         end else if (fwd) begin
            out_q <= new_req;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (fwd) begin
         if (!out_vld) begin
            out_q   <= new_req;
            out_vld <= 1'b1;
         end else begin
            skd_q   <= new_req;
            skd_vld <= 1'b1;
         end
      end
   end

   assign m_req_valid = out_vld;
   assign m_req_pid   = out_q.pid;
   assign m_req_len   = out_q.len;
   assign m_req_offs  = out_q.offs;

   assign q_pop  = mux_valid && mux_ready;
   assign q_head = q_mem[rd_ptr];

   always_ff @(posedge aclk) begin
      if (fwd) q_mem[wr_ptr] <= new_mux;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else begin
         if (fwd)   wr_ptr <= (wr_ptr == QB'(SEQ_DEPTH - 1)) ? '0 : wr_ptr + QB'(1);
         if (q_pop) rd_ptr <= (rd_ptr == QB'(SEQ_DEPTH - 1)) ? '0 : rd_ptr + QB'(1);
         if (fwd && !q_pop)      q_cnt <= q_cnt + CB'(1);
         else if (q_pop && !fwd) q_cnt <= q_cnt - CB'(1);
      end
   end

   assign mux_valid = (q_cnt != '0);
   assign mux_pid   = q_head.pid;
   assign mux_len   = q_head.len;
   assign mux_dest  = q_head.dest;
endmodule

// File: tb/tb_dest_req_arb_wrr.sv
// Directed bench for dest_req_arb_wrr: RR/WRR order, credits, drop filter, len, stalls, reset.

module tb_dest_req_arb_wrr;
   localparam int N = 4, WB = 4, PB = 6, LB = 16, OB = 8, DB = 2;

   logic                 aclk = 1'b0;
   logic                 aresetn = 1'b0;
   logic [N-1:0]         s_req_valid, s_req_ready;
   logic [N-1:0][PB-1:0] s_req_pid;
   logic [N-1:0][LB-1:0] s_req_len;
   logic [N-1:0][OB-1:0] s_req_offs;
   logic                 m_req_valid, m_req_ready;
   logic [PB-1:0]        m_req_pid;
   logic [LB-1:0]        m_req_len;
   logic [OB-1:0]        m_req_offs;
   logic                 mux_valid, mux_ready;
   logic [PB-1:0]        mux_pid;
   logic [LB-1:0]        mux_len;
   logic [DB-1:0]        mux_dest;
   logic                 cfg_mode, cfg_drop_en, cpl_valid;
   logic [N*WB-1:0]      cfg_weight;
   logic [DB-1:0]        cpl_dest;
   logic [31:0]          stat_drop_cnt;
   logic                 err_cpl_underflow;

   int n_tests = 0, n_fail = 0;

   always #5 aclk = ~aclk;

   dest_req_arb_wrr #(.N_DESTS(N), .WEIGHT_BITS(WB), .MAX_OUTST(3), .SEQ_DEPTH(4), .DROP_OFFS(6),
                      .PID_BITS(PB), .LEN_BITS(LB), .OFFS_BITS(OB), .BEAT_LOG_BITS(6)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_pid(s_req_pid),
      .s_req_len(s_req_len), .s_req_offs(s_req_offs),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_pid(m_req_pid),
      .m_req_len(m_req_len), .m_req_offs(m_req_offs),
      .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_pid(mux_pid), .mux_len(mux_len),
      .mux_dest(mux_dest),
      .cfg_mode(cfg_mode), .cfg_weight(cfg_weight), .cfg_drop_en(cfg_drop_en),
      .cpl_valid(cpl_valid), .cpl_dest(cpl_dest),
      .stat_drop_cnt(stat_drop_cnt), .err_cpl_underflow(err_cpl_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #2;
   endtask

   function automatic int gnt_of();
      for (int i = 0; i < N; i++)
         if (s_req_ready[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      aresetn     = 1'b0;
      s_req_valid = '0;
      cpl_valid   = 1'b0;
      cpl_dest    = '0;
      cfg_mode    = 1'b0;
      cfg_drop_en = 1'b0;
      cfg_weight  = '0;
      m_req_ready = 1'b1;
      mux_ready   = 1'b1;
      for (int i = 0; i < N; i++) begin
         s_req_pid[i]  = PB'(i + 1);
         s_req_len[i]  = LB'(64);
         s_req_offs[i] = '0;
      end
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic wait_gnt(input string tag, output int g);
      g = -1;
      #1;
      for (int c = 0; c < 10; c++) begin
         g = gnt_of();
         if (g >= 0) break;
         tick();
      end
      chk(tag, (g >= 0), 1);
   endtask

   int len_tab[4]  = '{128, 0, 65, 64};
   int mlen_tab[4] = '{1, 0, 1, 0};
   int wrr_tab[7]  = '{0, 0, 0, 1, 2, 3, 3};

   initial begin
      int g, n, hold_pid, changed;

      // reset values
      do_reset();
      aresetn = 1'b0;
      #1;
      chk("rst_mvalid", m_req_valid, 0);
      chk("rst_muxvalid", mux_valid, 0);
      chk("rst_ready", s_req_ready, 0);
      chk("rst_drop", stat_drop_cnt, 0);
      chk("rst_err", err_cpl_underflow, 0);

      // plain RR, one grant per cycle, mux len rounding
      do_reset();
      for (int i = 0; i < N; i++) s_req_len[i] = LB'(len_tab[i]);
      s_req_valid = 4'hf;
      wait_gnt("rr_wait", g);
      chk("rr_g0", g, 0);
      chk("rr_mv0", m_req_valid, 0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("rr_g", gnt_of(), k % 4);
         chk("rr_mvalid", m_req_valid, 1);
         chk("rr_mpid", m_req_pid, (k - 1) % 4 + 1);
         chk("rr_muxdest", mux_dest, (k - 1) % 4);
         chk("rr_muxlen", mux_len, mlen_tab[(k - 1) % 4]);
      end

      // weighted RR, weights {3,1,0,2}
      do_reset();
      cfg_mode    = 1'b1;
      cfg_weight  = 16'h2013;
      s_req_valid = 4'hf;
      wait_gnt("wrr_wait", g);
      chk("wrr_g", g, wrr_tab[0]);
      for (int k = 1; k < 7; k++) begin
         tick();
         chk("wrr_g", gnt_of(), wrr_tab[k]);
      end

      // outstanding limit and credit return
      do_reset();
      s_req_valid = 4'b0010;
      n = 0;
      #1;
      for (int c = 0; c < 10; c++) begin
         if (gnt_of() == 1) n++;
         tick();
      end
      chk("cred_fwd", n, 3);
      chk("cred_block", s_req_ready[1], 0);
      cpl_valid = 1'b1;
      cpl_dest  = 2'd1;
      #1;
      chk("cred_pre", s_req_ready[1], 0);
      tick();
      cpl_valid = 1'b0;
      #1;
      chk("cred_regrant", s_req_ready[1], 1);
      tick();
      chk("cred_reblock", s_req_ready[1], 0);
      chk("cred_err", err_cpl_underflow, 0);

      // drop filter
      do_reset();
      cfg_drop_en   = 1'b1;
      s_req_offs[2] = OB'(6);
      s_req_valid   = 4'b0100;
      wait_gnt("drop_wait", g);
      chk("drop_g", g, 2);
      tick();
      s_req_offs[2] = '0;
      #1;
      chk("drop_fwd_g", s_req_ready[2], 1);
      chk("drop_cnt1", stat_drop_cnt, 1);
      chk("drop_nomux", mux_valid, 0);
      chk("drop_nomreq", m_req_valid, 0);
      tick();
      s_req_valid = '0;
      #1;
      chk("drop_muxv", mux_valid, 1);
      chk("drop_muxdest", mux_dest, 2);
      chk("drop_moffs", m_req_offs, 0);
      chk("drop_cnt_hold", stat_drop_cnt, 1);

      // m_req stalled 20 cycles: two grants, head held stable
      do_reset();
      m_req_ready = 1'b0;
      s_req_valid = 4'hf;
      n = 0;
      hold_pid = -1;
      changed = 0;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (gnt_of() >= 0) n++;
         if (m_req_valid) begin
            if (hold_pid < 0) hold_pid = int'(m_req_pid);
            else if (int'(m_req_pid) != hold_pid) changed = 1;
         end
         tick();
      end
      chk("stall_gnts", n, 2);
      chk("stall_pid", m_req_pid, 1);
      chk("stall_changed", changed, 0);
      chk("stall_mvalid", m_req_valid, 1);

      // mux queue full: four forwarded, then drops still proceed
      do_reset();
      mux_ready   = 1'b0;
      s_req_valid = 4'hf;
      n = 0;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (gnt_of() >= 0) n++;
         tick();
      end
      chk("qfull_gnts", n, 4);
      chk("qfull_head", mux_dest, 0);
      cfg_drop_en   = 1'b1;
      s_req_offs[3] = OB'(6);
      n = 0;
      #1;
      for (int c = 0; c < 5; c++) begin
         if (gnt_of() == 3) n++;
         tick();
      end
      chk("qfull_drops", n, 5);
      chk("qfull_dropcnt", stat_drop_cnt, 5);
      chk("qfull_head2", mux_dest, 0);

      // completion underflow, then credits intact
      do_reset();
      #1;
      chk("uf_pre", err_cpl_underflow, 0);
      cpl_valid = 1'b1;
      cpl_dest  = 2'd3;
      tick();
      cpl_valid = 1'b0;
      chk("uf_err", err_cpl_underflow, 1);
      s_req_valid = 4'b1000;
      n = 0;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (gnt_of() == 3) n++;
         tick();
      end
      chk("uf_credit", n, 3);
      chk("uf_sticky", err_cpl_underflow, 1);

      // reset mid-traffic
      cfg_drop_en   = 1'b1;
      s_req_offs[0] = OB'(6);
      s_req_valid   = 4'hf;
      tick();
      tick();
      chk("mid_dropcnt", (stat_drop_cnt != 0), 1);
      aresetn = 1'b0;
      #1;
      chk("mid_mvalid", m_req_valid, 0);
      chk("mid_muxvalid", mux_valid, 0);
      chk("mid_ready", s_req_ready, 0);
      chk("mid_drop", stat_drop_cnt, 0);
      chk("mid_err", err_cpl_underflow, 0);
      tick();
      aresetn = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
